// File: rtl/trigger_seq_pkg.sv
// rtl/trigger_seq_pkg.sv - shared types, field positions and config decode for trigger_seq
//
// Purpose: per-stage config struct, config-word bit positions, sequencer state
// encoding and the helper that unpacks a config command word.
// Ports: none (package).

package trigger_seq_pkg;

  localparam int TRG_MAX_STAGES = 16;
  localparam int TRG_MAX_WIDTH  = 32;

  // Config word layout (cmd_i)
  localparam int CFG_DELAY_LSB  = 0;
  localparam int CFG_LEVEL_LSB  = 16;
  localparam int CFG_CHAN_LSB   = 20;
  localparam int CFG_SERIAL_BIT = 26;
  localparam int CFG_START_BIT  = 27;

  typedef struct packed {
    logic        start;
    logic        serial;
    logic [4:0]  channel;
    logic [3:0]  level;
    logic [15:0] delay;
  } trg_cfg_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_RUN   = 2'd2
  } seq_state_t;

  // Unpack a config word; level and delay only keep the bits that the
  // instance actually uses, so the upper bits compare/load as zero.
  function automatic trg_cfg_t cfg_decode(input logic [31:0] cmd,
                                          input int lvl_w,
                                          input int delay_w);
    trg_cfg_t c;
    c         = '0;
    c.start   = cmd[CFG_START_BIT];
    c.serial  = cmd[CFG_SERIAL_BIT];
    c.channel = cmd[CFG_CHAN_LSB +: 5];
    for (int b = 0; b < 4; b++) begin
      c.level[b] = (b < lvl_w) ? cmd[CFG_LEVEL_LSB + b] : 1'b0;
    end
    for (int b = 0; b < 16; b++) begin
      c.delay[b] = (b < delay_w) ? cmd[CFG_DELAY_LSB + b] : 1'b0;
    end
    return c;
  endfunction

endpackage

// File: rtl/trigger_seq_stage.sv
// rtl/trigger_seq_stage.sv - one trigger stage: match logic, serial shifter, delay counter
//
// Purpose: holds mask/value/config for one stage, evaluates a match on each
// sample strobe while armed, optionally delays the fire by N strobes, and
// fires at most once per arm.
// Ports:
//   clk_i, rst_in          clock, async active-low reset
//   arm_i                  clear per-arm state (fired, pending, counter, shifter)
//   set_mask_i/val_i/cfg_i config writes already decoded for this stage
//   cmd_i[31:0]            config payload
//   active_i               sequencer armed and not yet run
//   stb_i, smpls_i         sample strobe and channels
//   lvl_i                  current sequence level
//   fire_o                 stage fires this cycle (combinational)
//   start_o                stage config requests capture start on fire

module trigger_seq_stage
  import trigger_seq_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int DELAY_W = 16,
  parameter int LVL_W   = 2
) (
  input  logic             clk_i,
  input  logic             rst_in,
  input  logic             arm_i,
  input  logic             set_mask_i,
  input  logic             set_val_i,
  input  logic             set_cfg_i,
  input  logic [31:0]      cmd_i,
  input  logic             active_i,
  input  logic             stb_i,
  input  logic [WIDTH-1:0] smpls_i,
  input  logic [LVL_W-1:0] lvl_i,
  output logic             fire_o,
  output logic             start_o
);

  logic [WIDTH-1:0]   mask_q;
  logic [WIDTH-1:0]   val_q;
  logic [WIDTH-1:0]   shreg_q;
  logic [WIDTH-1:0]   shreg_next;
  logic [WIDTH:0]     shift_full;
  logic [WIDTH-1:0]   sample;
  trg_cfg_t           cfg_q;
  logic [DELAY_W-1:0] cnt_q;
  logic               pending_q;
  logic               fired_q;

  logic [31:0] smpls_ext;
  logic        ch_bit;
  logic        eval;
  logic        eligible;
  logic        hit;
  logic        match_take;
  logic        delay_zero;
  logic        unused_bits;

  // Out-of-range channel selects read as a constant 0.
  assign smpls_ext  = 32'(smpls_i);
  assign ch_bit     = (32'(cfg_q.channel) < 32'(WIDTH)) ? smpls_ext[cfg_q.channel] : 1'b0;
  assign shift_full = {shreg_q, ch_bit};
  assign shreg_next = shift_full[WIDTH-1:0];

  // arm_i has priority over any evaluation in the same cycle.
  assign eval       = active_i & stb_i & ~arm_i;
  assign sample     = cfg_q.serial ? shreg_next : smpls_i;
  assign hit        = ((sample ^ val_q) & mask_q) == '0;
  assign eligible   = ~fired_q & ~pending_q & (cfg_q.level == 4'(lvl_i));
  assign delay_zero = cfg_q.delay[DELAY_W-1:0] == '0;
  assign match_take = eval & eligible & hit;

  // A pending stage fires on the strobe that takes its counter from 1 to 0.
  assign fire_o  = (match_take & delay_zero) | (eval & pending_q & (cnt_q == DELAY_W'(1)));
  assign start_o = cfg_q.start;

  assign unused_bits = ^{shift_full[WIDTH], cfg_q.delay, cmd_i};

  always_ff @(posedge clk_i or negedge rst_in) begin
    if (!rst_in) begin
      mask_q <= '0;
      val_q  <= '0;
      cfg_q  <= '0;
    end else begin
      if (set_mask_i) mask_q <= cmd_i[WIDTH-1:0];
      if (set_val_i)  val_q  <= cmd_i[WIDTH-1:0];
      if (set_cfg_i)  cfg_q  <= cfg_decode(cmd_i, LVL_W, DELAY_W);
    end
  end

  always_ff @(posedge clk_i or negedge rst_in) begin
    if (!rst_in) begin
      shreg_q   <= '0;
      cnt_q     <= '0;
      pending_q <= 1'b0;
      fired_q   <= 1'b0;
    end else if (arm_i) begin
      shreg_q   <= '0;
      cnt_q     <= '0;
      pending_q <= 1'b0;
      fired_q   <= 1'b0;
    end else begin
      // The shifter runs on every strobe while armed, eligible or not.
      if (active_i && stb_i) shreg_q <= shreg_next;
      if (fire_o) begin
        fired_q   <= 1'b1;
        pending_q <= 1'b0;
        cnt_q     <= '0;
      end else if (match_take) begin
        pending_q <= 1'b1;
        cnt_q     <= cfg_q.delay[DELAY_W-1:0];
      end else if (eval && pending_q) begin
        cnt_q <= cnt_q - DELAY_W'(1);
      end
    end
  end

endmodule

// File: rtl/trigger_seq.sv
// rtl/trigger_seq.sv - parametrised multi-stage sequential trigger
//
// Purpose: sequences STAGES trigger stages against the sampler stream and
// raises run_o (sticky until next arm) when a stage configured as start fires.
// Ports:
//   clk_i, rst_in              clock, async active-low reset
//   cmd_i[31:0]                mask/value/config payload
//   stg_i[LVL_W-1:0]           stage addressed by set_* strobes
//   set_mask_i/val_i/cfg_i     config write strobes
//   arm_i                      clear sequence state and start matching
//   stb_i, smpls_i[WIDTH-1:0]  sample strobe and channels
//   run_o                      capture start
//   lvl_o[LVL_W-1:0]           current sequence level
//   armed_o                    armed and not yet run

module trigger_seq
  import trigger_seq_pkg::*;
#(
  parameter int STAGES  = 4,
  parameter int WIDTH   = 32,
  parameter int DELAY_W = 16,
  parameter int LVL_W   = (STAGES > 1) ? $clog2(STAGES) : 1
) (
  input  logic             clk_i,
  input  logic             rst_in,
  input  logic [31:0]      cmd_i,
  input  logic [LVL_W-1:0] stg_i,
  input  logic             set_mask_i,
  input  logic             set_val_i,
  input  logic             set_cfg_i,
  input  logic             arm_i,
  input  logic             stb_i,
  input  logic [WIDTH-1:0] smpls_i,
  output logic             run_o,
  output logic [LVL_W-1:0] lvl_o,
  output logic             armed_o
);

  localparam logic [LVL_W-1:0] LVL_MAX = LVL_W'(STAGES - 1);

  seq_state_t        state_q, state_d;
  logic [LVL_W-1:0]  lvl_q, lvl_d;
  logic [STAGES-1:0] fire;
  logic [STAGES-1:0] start;
  logic              active;
  logic              any_fire;
  logic              any_start;

  assign active = (state_q == ST_ARMED);

  // Addresses >= STAGES match no stage, so such writes fall away.
  for (genvar i = 0; i < STAGES; i++) begin : g_stage
    logic sel;
    assign sel = (stg_i == LVL_W'(i));

    trigger_seq_stage #(
      .WIDTH   (WIDTH),
      .DELAY_W (DELAY_W),
      .LVL_W   (LVL_W)
    ) u_stage (
      .clk_i      (clk_i),
      .rst_in     (rst_in),
      .arm_i      (arm_i),
      .set_mask_i (set_mask_i & sel),
      .set_val_i  (set_val_i & sel),
      .set_cfg_i  (set_cfg_i & sel),
      .cmd_i      (cmd_i),
      .active_i   (active),
      .stb_i      (stb_i),
      .smpls_i    (smpls_i),
      .lvl_i      (lvl_q),
      .fire_o     (fire[i]),
      .start_o    (start[i])
    );
  end

  assign any_fire  = |fire;
  assign any_start = |(fire & start);

  always_comb begin
    state_d = state_q;
    lvl_d   = lvl_q;
    if (arm_i) begin
      state_d = ST_ARMED;
      lvl_d   = '0;
    end else if (active && any_fire) begin
      // Several stages firing together still advance the level by one.
      if (lvl_q != LVL_MAX) lvl_d = lvl_q + LVL_W'(1);
      if (any_start) state_d = ST_RUN;
    end
  end

  always_ff @(posedge clk_i or negedge rst_in) begin
    if (!rst_in) begin
      state_q <= ST_IDLE;
      lvl_q   <= '0;
    end else begin
      state_q <= state_d;
      lvl_q   <= lvl_d;
    end
  end

  assign run_o   = (state_q == ST_RUN);
  assign armed_o = (state_q == ST_ARMED);
  assign lvl_o   = lvl_q;

endmodule
